// File: rtl/axi_lite_txn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_txn_arbiter_if
// Brief    : Requester, master-command and status bundle for the arbiter.
// Revision : 1.0
// ============================================================================
interface axi_lite_txn_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req1_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req0_data;
    logic [DATA_W-1:0] req1_data;
    logic              req0_ready;
    logic              req1_ready;
    logic              req0_done;
    logic              req1_done;
    logic              req0_error;
    logic              req1_error;
    logic              m_txn_start;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_done;
    logic              m_error;
    logic              busy;
    logic              grant_id;
    logic              timeout_flag;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
        input  m_done, m_error,
        output req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error,
        output m_txn_start, m_addr, m_data, busy, grant_id, timeout_flag
    );

    // Requester / master-model side
    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
        output m_done, m_error,
        input  req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error,
        input  m_txn_start, m_addr, m_data, busy, grant_id, timeout_flag
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_txn_arbiter
// Brief    : Round-robin sharing of one AXI4-Lite write master by two sources.
// Revision : 1.0
// ============================================================================
module axi_lite_txn_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_lite_txn_arbiter_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              grant_id_q;
    logic              ready0_q, ready1_q;
    logic              done0_q, done1_q;
    logic              err0_q, err1_q;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              tflag_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              grant_d;
    logic              any_req_d;
    logic [CNT_W-1:0]  cnt_d;

    // On a tie the requester that did not win last time gets the grant
    always_comb begin
        any_req_d = bus.req0_valid | bus.req1_valid;
        grant_d   = ~last_grant_q;
        if (!(bus.req0_valid && bus.req1_valid)) begin
            grant_d = bus.req1_valid;
        end
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            start_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            tflag_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            start_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        grant_id_q   <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= grant_d ? bus.req1_addr : bus.req0_addr;
                        data_q       <= grant_d ? bus.req1_data : bus.req0_data;
                        ready0_q     <= ~grant_d;
                        ready1_q     <= grant_d;
                        start_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over the watchdog limit
                    if (bus.m_done) begin
                        done0_q <= ~grant_id_q;
                        done1_q <= grant_id_q;
                        err0_q  <= ~grant_id_q & bus.m_error;
                        err1_q  <= grant_id_q & bus.m_error;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (TIMEOUT != 0 && cnt_q != CNT_LIMIT) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_LIMIT) begin
                            tflag_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready   = ready0_q;
    assign bus.req1_ready   = ready1_q;
    assign bus.req0_done    = done0_q;
    assign bus.req1_done    = done1_q;
    assign bus.req0_error   = err0_q;
    assign bus.req1_error   = err1_q;
    assign bus.m_txn_start  = start_q;
    assign bus.m_addr       = addr_q;
    assign bus.m_data       = data_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.timeout_flag = tflag_q;
endmodule
`default_nettype wire

// File: doc/axi_lite_txn_arbiter.md
# axi_lite_txn_arbiter

Two-requester round-robin arbiter that shares one AXI4-Lite write master between two internal command sources. It sits between the requesters and the master's command port (`INT_AXI_TXN` / `tgt_addr` / `tgt_data` / `txn_done` / `txn_error`). It holds one transaction in flight at a time, routes the completion status back to the requester that issued it, and runs a watchdog on the master's completion.

## Interface
Parameters:
- `ADDR_W`, 4, address width; matches master `tgt_addr`.
- `DATA_W`, 32, data width; matches master `tgt_data`.
- `TIMEOUT`, 255, WAIT-state cycle limit before `timeout_flag` sets; 0 disables the watchdog.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  requester N has a command pending.
- `req0_addr`, `req1_addr`  in  ADDR_W  command address.
- `req0_data`, `req1_data`  in  DATA_W  command write data.
- `req0_ready`, `req1_ready`  out  1  one-cycle pulse: command accepted.
- `req0_done`, `req1_done`  out  1  one-cycle pulse: requester N's transaction completed.
- `req0_error`, `req1_error`  out  1  valid with `reqN_done`; 1 = non-OKAY response.
- `m_txn_start`  out  1  one-cycle pulse to master `INT_AXI_TXN`.
- `m_addr`  out  ADDR_W  to master `tgt_addr`.
- `m_data`  out  DATA_W  to master `tgt_data`.
- `m_done`  in  1  master `txn_done`.
- `m_error`  in  1  master `txn_error`.
- `busy`  out  1  high whenever state is not IDLE.
- `grant_id`  out  1  requester owning the current or most recent transaction.
- `timeout_flag`  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- **IDLE**
  - Sample `req0_valid` and `req1_valid`. If either is high, grant one requester. Register `m_addr`/`m_data` from that requester's payload and set `grant_id`. Pulse `reqN_ready` and `m_txn_start`. Go to ISSUE.
  - If neither is high, stay in IDLE.
- **Arbitration**
  - A single valid requester wins.
  - If both are valid, the requester not equal to `last_grant` wins.
  - `last_grant` updates on every grant. It resets to 1, so requester 0 wins the first tie.
- **ISSUE**: deassert `m_txn_start` and `reqN_ready`; go to WAIT unconditionally.
- **WAIT**
  - On `m_done`=1: pulse `reqN_done` with `reqN_error` = `m_error` for requester `grant_id`. The other requester's done/error stay 0. Go to IDLE.
- **Watchdog**
  - Counter of width clog2(TIMEOUT+1). It clears on entry to WAIT and increments each WAIT cycle without `m_done`.
  - When it reaches TIMEOUT, set `timeout_flag`. The block stays in WAIT.
  - If `m_done` arrives on the same cycle as the limit is reached, `m_done` wins and the flag is not set.
- **Requester contract**
  - Hold valid and payload stable until `reqN_ready` is seen, then drop valid the following cycle.
  - Valid is sampled only in IDLE. Valid still high on return to IDLE is treated as a new command.
- `m_done`/`m_error` are ignored in IDLE and ISSUE.
- **Reset**: applies at any point, including mid-WAIT. State returns to IDLE, `last_grant` to 1, and the watchdog counter to 0. The transaction in flight is abandoned and no done pulse is issued.

## Timing
- Reset values are 0 for every output: all `reqN_ready`/`reqN_done`/`reqN_error`, `m_txn_start`, `m_addr`, `m_data`, `busy`, `grant_id`, `timeout_flag`.
- Accept latency: valid sampled in IDLE at edge E. `reqN_ready`, `m_txn_start` and `busy` are high in cycle E+1, with `m_addr`/`m_data` already valid. `m_txn_start` is exactly 1 cycle wide.
- `m_addr`/`m_data` hold stable from E+1 until the next grant.
- Completion latency: `m_done` sampled at edge D gives `reqN_done` high in cycle D+1 for 1 cycle. `busy` is low in D+1.
- Back-to-back: a new grant can occur at edge D+1, so `m_txn_start` for the next command is high in D+2.
- Minimum arbiter overhead per transaction is 3 cycles plus master latency.

## Test plan
- Single req0: addr 4'h4, data 32'hDEADBEEF; master model asserts `m_done` 5 cycles after start with `m_error`=0. Required: `m_addr`=4'h4, `m_data`=32'hDEADBEEF, `m_txn_start` one 1-cycle pulse, `req0_done`=1 for 1 cycle, `req0_error`=0, `req1_*`=0, `grant_id`=0.
- Both requesters held valid after reset, each dropping valid after its ready and re-raising it. Required: grants alternate 0,1,0,1 over 4 transactions; `grant_id` matches each; payloads routed correctly.
- req1 command with the master returning `m_error`=1. Required: `req1_done`=1 and `req1_error`=1 in the same cycle; `req0_done`=0 and `req0_error`=0.
- TIMEOUT=16 with `m_done` withheld. Required: `timeout_flag` rises after 16 WAIT cycles and `busy` stays 1. Then `m_done` at cycle 30: `reqN_done` pulses, `timeout_flag` stays 1.
- `aresetn` low for 1 cycle mid-WAIT. Required: all outputs 0 the next cycle, no done pulse, and the next tie is won by req0.
- `m_done` pulse injected in IDLE with no requests pending. Required: no `reqN_done`, state stays IDLE, `busy`=0.
